// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank with byte strobes, read-only slots fed from hw_in,
// and SLVERR for out-of-range or read-only writes. One outstanding write and one outstanding read.
module axil_reg_bank #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                             aclk,
    input  logic                             areset_n,
    input  logic                             AWVALID,
    output logic                             AWREADY,
    input  logic [ADDR_WIDTH-1:0]            AWADDR,
    input  logic                             WVALID,
    output logic                             WREADY,
    input  logic [DATA_WIDTH-1:0]            WDATA,
    input  logic [DATA_WIDTH/8-1:0]          WSTRB,
    output logic                             BVALID,
    input  logic                             BREADY,
    output logic [1:0]                       BRESP,
    input  logic                             ARVALID,
    output logic                             ARREADY,
    input  logic [ADDR_WIDTH-1:0]            ARADDR,
    output logic                             RVALID,
    input  logic                             RREADY,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [1:0]                       RRESP,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
    output logic [NUM_REGS-1:0]              wr_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[LSB +: IDX_W];
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return ((addr >> (LSB + IDX_W)) == '0) && (int'(addr[LSB +: IDX_W]) < NUM_REGS);
    endfunction

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  aw_ok_q, aw_ok_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        aw_ok_d    = aw_ok_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        if (AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = addr_idx(AWADDR);
            aw_ok_d   = addr_ok(AWADDR);
        end
        if (WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end
        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
        if (aw_held_q && w_held_q && !bvalid_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = 2'b10;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_ok_q && !RO_MASK[i] && aw_idx_q == IDX_W'(i)) begin
                    bresp_d       = 2'b00;
                    wr_pulse_d[i] = 1'b1;
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                    end
                end
            end
        end
        // Readies are computed from next state so they drop on the accepting edge.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 2'b10;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_ok(ARADDR) && addr_idx(ARADDR) == IDX_W'(i)) begin
                    rresp_d = 2'b00;
                    rdata_d = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                end
            end
        end
        // ARREADY stays low for the cycle after the R handshake.
        arready_d = !rvalid_q && !rvalid_d;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            aw_ok_q    <= 1'b0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            aw_ok_q    <= aw_ok_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: 16 x 32-bit registers, slot 3 read-only.
module tb_axil_reg_bank;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic [DW-1:0]     WDATA, RDATA;
    logic [DW/8-1:0]   WSTRB;
    logic [1:0]        BRESP, RRESP;
    logic [NR*DW-1:0]  hw_in, reg_out;
    logic [NR-1:0]     wr_pulse;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [15:0] pls;

    always #5 aclk = ~aclk;

    axil_reg_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (16'h0008),
        .RESET_VALUE(32'h0)
    ) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .hw_in   (hw_in),
        .reg_out (reg_out),
        .wr_pulse(wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [15:0] pulse);
        int   n;
        logic aw_done, w_done, awr, wr;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            awr = AWREADY;
            wr  = WREADY;
            tick();
            n++;
            if (awr) begin aw_done = 1'b1; AWVALID = 1'b0; end
            if (wr)  begin w_done  = 1'b1; WVALID  = 1'b0; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        chk("bvalid_wait", BVALID, 1);
        resp  = BRESP;
        pulse = wr_pulse;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        ARADDR = addr; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        chk("rvalid_wait", RVALID, 1);
        data = RDATA;
        resp = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        areset_n = 1'b0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        hw_in = '0;
        hw_in[3*DW +: DW] = 32'h5A5A0001;
        repeat (3) tick();

        // Reset release: readies low until the next edge.
        areset_n = 1'b1;
        chk("rst_readies_c0", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
        chk("rst_rdata", RDATA, 0);
        tick();
        chk("rst_readies_c1", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("rst_regs_zero", (reg_out == '0), 1);
        chk("rst_pulse", wr_pulse, 0);

        // AW first at cycle 0, W at cycle 3, response at cycle 4.
        AWADDR = 32'h08; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("t2_aw_held", {AWREADY, WREADY}, 2'b01);
        tick(); tick();
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t2_bvalid_c3", BVALID, 0);
        chk("t2_readies_c3", {AWREADY, WREADY}, 2'b00);
        tick();
        chk("t2_bvalid_c4", BVALID, 1);
        chk("t2_bresp", BRESP, 2'b00);
        chk("t2_pulse", wr_pulse, 16'h0004);
        chk("t2_reg_out", reg_out[2*DW +: DW], 32'hDEADBEEF);
        tick();
        chk("t2_pulse_once", wr_pulse, 16'h0000);
        chk("t2_bvalid_hold", BVALID, 1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("t2_b_done", {BVALID, AWREADY, WREADY}, 3'b011);
        axi_read(32'h08, rd, rsp);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_rresp", rsp, 2'b00);

        // Byte strobes and the empty-strobe write.
        axi_write(32'h04, 32'h11223344, 4'hF, rsp, pls);
        chk("t3_full_resp", rsp, 2'b00);
        chk("t3_full_pulse", pls, 16'h0002);
        axi_write(32'h04, 32'hAABBCCDD, 4'h5, rsp, pls);
        chk("t3_strb_resp", rsp, 2'b00);
        axi_read(32'h04, rd, rsp);
        chk("t3_strb_rdata", rd, 32'h11BB33DD);
        axi_write(32'h04, 32'hFFFFFFFF, 4'h0, rsp, pls);
        chk("t3_nostrb_resp", rsp, 2'b00);
        chk("t3_nostrb_pulse", pls, 16'h0002);
        axi_read(32'h04, rd, rsp);
        chk("t3_nostrb_rdata", rd, 32'h11BB33DD);

        // Out-of-range decode and the top valid slot.
        axi_write(32'h40, 32'h12345678, 4'hF, rsp, pls);
        chk("t4_oor_bresp", rsp, 2'b10);
        chk("t4_oor_pulse", pls, 16'h0000);
        chk("t4_oor_nochange", reg_out[0 +: DW], 32'h0);
        axi_read(32'h1000, rd, rsp);
        chk("t4_oor_rdata", rd, 32'h0);
        chk("t4_oor_rresp", rsp, 2'b10);
        axi_read(32'h3C, rd, rsp);
        chk("t4_last_rresp", rsp, 2'b00);
        axi_read(32'h0B, rd, rsp);
        chk("t4_lowbits_rdata", rd, 32'hDEADBEEF);

        // Read-only slot.
        axi_write(32'h0C, 32'hFFFF0000, 4'hF, rsp, pls);
        chk("t5_ro_bresp", rsp, 2'b10);
        chk("t5_ro_pulse", pls, 16'h0000);
        axi_read(32'h0C, rd, rsp);
        chk("t5_ro_rdata", rd, 32'h5A5A0001);
        chk("t5_ro_rresp", rsp, 2'b00);
        chk("t5_ro_reg_out", reg_out[3*DW +: DW], 32'h0);

        // W before AW.
        WDATA = 32'h1234CAFE; WSTRB = 4'h3; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("tw_w_held", {AWREADY, WREADY}, 2'b10);
        AWADDR = 32'h18; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("tw_bvalid_early", BVALID, 0);
        tick();
        chk("tw_bvalid", BVALID, 1);
        chk("tw_pulse", wr_pulse, 16'h0040);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        axi_read(32'h18, rd, rsp);
        chk("tw_rdata", rd, 32'h0000CAFE);

        // Response back-pressure, then reset in the middle of it.
        AWADDR = 32'h14; WDATA = 32'h12345678; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("t6_reg5", reg_out[5*DW +: DW], 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold", {AWREADY, WREADY, BVALID, BRESP}, 5'b00100);
            tick();
        end
        #2;
        areset_n = 1'b0;
        #1;
        chk("t6_rst_bvalid", BVALID, 0);
        chk("t6_rst_regs", (reg_out == '0), 1);
        chk("t6_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
